// File: rtl/ham_8_4_pkg.sv
// Hamming(8,4) SECDED shared definitions.
// Holds the check-bit function used by both the encoder and the decoder,
// and the syndrome value that points at each codeword bit.
package ham_8_4_pkg;

  // Syndrome values {s2,s1,s0} naming the erroneous bit position.
  localparam logic [2:0] SYN_NONE = 3'd0;
  localparam logic [2:0] SYN_C0   = 3'd1;
  localparam logic [2:0] SYN_C1   = 3'd2;
  localparam logic [2:0] SYN_D0   = 3'd3;
  localparam logic [2:0] SYN_C2   = 3'd4;
  localparam logic [2:0] SYN_D1   = 3'd5;
  localparam logic [2:0] SYN_D2   = 3'd6;
  localparam logic [2:0] SYN_D3   = 3'd7;

  // Returns {p3,p2,p1,p0}. p3 makes the full 8-bit codeword parity even.
  function automatic logic [3:0] ham_8_4_parity(input logic [3:0] d);
    logic [3:0] p;
    p[0] = d[0] ^ d[1] ^ d[3];
    p[1] = d[0] ^ d[2] ^ d[3];
    p[2] = d[1] ^ d[2] ^ d[3];
    p[3] = d[0] ^ d[1] ^ d[2];
    return p;
  endfunction

endpackage

// File: rtl/ham_check_8_4.sv
// Combinational Hamming(8,4) SECDED checker.
// Ports:
//   data_i           received data bits d[3:0]
//   code_i           received check bits {c3,c2,c1,c0}
//   error_o          any error detected (single or double)
//   fatal_o          uncorrectable double error
//   corrected_data_o data with a single data-bit error repaired
module ham_check_8_4
  import ham_8_4_pkg::*;
(
  input  logic [3:0] data_i,
  input  logic [3:0] code_i,
  output logic       error_o,
  output logic       fatal_o,
  output logic [3:0] corrected_data_o
);

  logic [3:0] expect_code;
  logic [2:0] syndrome;
  logic       overall;

  // Recomputing the check bits and XORing with the received ones yields
  // exactly the s0..s2 equations; bit 3 is not used for the syndrome.
  assign expect_code = ham_8_4_parity(data_i);
  assign syndrome    = expect_code[2:0] ^ code_i[2:0];
  assign overall     = (^data_i) ^ (^code_i);

  always_comb begin
    error_o          = 1'b0;
    fatal_o          = 1'b0;
    corrected_data_o = data_i;
    if (syndrome == SYN_NONE) begin
      // Clean, or only c3 flipped: data is already good.
      error_o = overall;
    end else if (!overall) begin
      // Nonzero syndrome with even parity means two bits flipped.
      error_o = 1'b1;
      fatal_o = 1'b1;
    end else begin
      error_o = 1'b1;
      case (syndrome)
        SYN_D0:  corrected_data_o[0] = ~data_i[0];
        SYN_D1:  corrected_data_o[1] = ~data_i[1];
        SYN_D2:  corrected_data_o[2] = ~data_i[2];
        SYN_D3:  corrected_data_o[3] = ~data_i[3];
        default: corrected_data_o = data_i;  // check-bit error
      endcase
    end
  end

endmodule

// File: rtl/ham_8_4_codec.sv
// Registered Hamming(8,4) SECDED codec, one cycle latency on each path.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   enc_data_i        data to encode
//   enc_code_o        registered check bits {p3,p2,p1,p0}
//   dec_valid_i       decode inputs valid this cycle
//   dec_data_i        received data bits
//   dec_code_i        received check bits
//   dec_valid_o       dec_valid_i delayed one cycle
//   error_o           any error, qualified by valid
//   fatal_o           double error, qualified by valid
//   corrected_data_o  corrected data (registered regardless of valid)
//   err_cnt_o         saturating count of corrected single errors
//   fatal_cnt_o       saturating count of double errors
module ham_8_4_codec
  import ham_8_4_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       enc_data_i,
  output logic [3:0]       enc_code_o,
  input  logic             dec_valid_i,
  input  logic [3:0]       dec_data_i,
  input  logic [3:0]       dec_code_i,
  output logic             dec_valid_o,
  output logic             error_o,
  output logic             fatal_o,
  output logic [3:0]       corrected_data_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] fatal_cnt_o
);

  logic       chk_error;
  logic       chk_fatal;
  logic [3:0] chk_data;

  ham_check_8_4 u_check (
    .data_i           (dec_data_i),
    .code_i           (dec_code_i),
    .error_o          (chk_error),
    .fatal_o          (chk_fatal),
    .corrected_data_o (chk_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_code_o       <= '0;
      dec_valid_o      <= 1'b0;
      error_o          <= 1'b0;
      fatal_o          <= 1'b0;
      corrected_data_o <= '0;
      err_cnt_o        <= '0;
      fatal_cnt_o      <= '0;
    end else begin
      enc_code_o       <= ham_8_4_parity(enc_data_i);
      dec_valid_o      <= dec_valid_i;
      error_o          <= dec_valid_i & chk_error;
      fatal_o          <= dec_valid_i & chk_fatal;
      corrected_data_o <= chk_data;
      // Fatal wins, so a double error never also bumps the single count.
      if (dec_valid_i && chk_fatal) begin
        if (fatal_cnt_o != '1) fatal_cnt_o <= fatal_cnt_o + CNT_W'(1);
      end else if (dec_valid_i && chk_error) begin
        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ham_8_4_codec.sv
module tb_ham_8_4_codec;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] enc_data_i;
  logic [3:0] enc_code_o;
  logic       dec_valid_i;
  logic [3:0] dec_data_i;
  logic [3:0] dec_code_i;
  logic       dec_valid_o;
  logic       error_o;
  logic       fatal_o;
  logic [3:0] corrected_data_o;
  logic [7:0] err_cnt_o;
  logic [7:0] fatal_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Hand-computed {p3,p2,p1,p0} for d = 0..15.
  logic [3:0] enc_tbl [16] = '{4'h0, 4'hB, 4'hD, 4'h6, 4'hE, 4'h5, 4'h3, 4'h8,
                               4'h7, 4'hC, 4'hA, 4'h1, 4'h9, 4'h2, 4'h4, 4'hF};

  ham_8_4_codec #(.CNT_W(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .enc_data_i       (enc_data_i),
    .enc_code_o       (enc_code_o),
    .dec_valid_i      (dec_valid_i),
    .dec_data_i       (dec_data_i),
    .dec_code_i       (dec_code_i),
    .dec_valid_o      (dec_valid_o),
    .error_o          (error_o),
    .fatal_o          (fatal_o),
    .corrected_data_o (corrected_data_o),
    .err_cnt_o        (err_cnt_o),
    .fatal_cnt_o      (fatal_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".enc"},   32'(enc_code_o), 0);
    chk({tag, ".vld"},   32'(dec_valid_o), 0);
    chk({tag, ".err"},   32'(error_o), 0);
    chk({tag, ".fatal"}, 32'(fatal_o), 0);
    chk({tag, ".data"},  32'(corrected_data_o), 0);
    chk({tag, ".ecnt"},  32'(err_cnt_o), 0);
    chk({tag, ".fcnt"},  32'(fatal_cnt_o), 0);
  endtask

  task automatic dec(input string tag, input logic v, input logic [3:0] d, input logic [3:0] c,
                     input logic [3:0] e_data, input logic e_err, input logic e_fatal,
                     input int e_ecnt, input int e_fcnt);
    dec_valid_i = v;
    dec_data_i  = d;
    dec_code_i  = c;
    tick();
    chk({tag, ".vld"},   32'(dec_valid_o), 32'(v));
    chk({tag, ".data"},  32'(corrected_data_o), 32'(e_data));
    chk({tag, ".err"},   32'(error_o), 32'(e_err));
    chk({tag, ".fatal"}, 32'(fatal_o), 32'(e_fatal));
    chk({tag, ".ecnt"},  32'(err_cnt_o), 32'(e_ecnt));
    chk({tag, ".fcnt"},  32'(fatal_cnt_o), 32'(e_fcnt));
  endtask

  initial begin
    reset       = 1'b1;
    enc_data_i  = 4'hF;
    dec_valid_i = 1'b1;
    dec_data_i  = 4'b1111;
    dec_code_i  = 4'b0001;
    #1;
    tick();
    tick();
    check_zero("rst");

    // Encode path: first output after release reflects the release-edge sample.
    reset       = 1'b0;
    dec_valid_i = 1'b0;
    dec_data_i  = 4'h0;
    dec_code_i  = 4'h0;
    enc_data_i = 4'h0;    tick(); chk("enc_0", 32'(enc_code_o), 32'h0);
    enc_data_i = 4'hF;    tick(); chk("enc_f", 32'(enc_code_o), 32'hF);
    enc_data_i = 4'b0001; tick(); chk("enc_1", 32'(enc_code_o), 32'hB);
    enc_data_i = 4'b1011; tick(); chk("enc_b", 32'(enc_code_o), 32'h1);
    for (int i = 0; i < 16; i++) begin
      enc_data_i = 4'(i);
      tick();
      chk($sformatf("sweep_%0d", i), 32'(enc_code_o), 32'(enc_tbl[i]));
      chk($sformatf("par_%0d", i), 32'(^{4'(i), enc_code_o}), 0);
    end
    enc_data_i = 4'h0;

    dec("clean",  1, 4'b1011, 4'b0001, 4'b1011, 0, 0, 0, 0);
    dec("sd2",    1, 4'b1111, 4'b0001, 4'b1011, 1, 0, 1, 0);
    dec("sc3",    1, 4'b1011, 4'b1001, 4'b1011, 1, 0, 2, 0);
    dec("sc0",    1, 4'b1011, 4'b0000, 4'b1011, 1, 0, 3, 0);
    dec("sc1",    1, 4'b1011, 4'b0011, 4'b1011, 1, 0, 4, 0);
    dec("sc2",    1, 4'b1011, 4'b0101, 4'b1011, 1, 0, 5, 0);
    dec("sd0",    1, 4'b1010, 4'b0001, 4'b1011, 1, 0, 6, 0);
    dec("sd3",    1, 4'b0011, 4'b0001, 4'b1011, 1, 0, 7, 0);
    dec("dbl",    1, 4'b1000, 4'b0001, 4'b1000, 1, 1, 7, 1);
    dec("nv_dbl", 0, 4'b1000, 4'b0001, 4'b1000, 0, 0, 7, 1);
    dec("nv_sgl", 0, 4'b1111, 4'b0001, 4'b1011, 0, 0, 7, 1);

    // Reset mid-stream with a valid single error and a nonzero encode input.
    enc_data_i  = 4'hF;
    dec_valid_i = 1'b1;
    dec_data_i  = 4'b1111;
    dec_code_i  = 4'b0001;
    reset       = 1'b1;
    tick();
    check_zero("mid_rst");
    reset = 1'b0;
    dec("post_rst", 1, 4'b1111, 4'b0001, 4'b1011, 1, 0, 1, 0);
    chk("post_rst.enc", 32'(enc_code_o), 32'hF);

    // Saturation: 299 more single errors (300 total since reset).
    dec_valid_i = 1'b1;
    dec_data_i  = 4'b1111;
    dec_code_i  = 4'b0001;
    for (int i = 0; i < 253; i++) tick();
    chk("cnt_254", 32'(err_cnt_o), 254);
    tick();
    chk("cnt_255", 32'(err_cnt_o), 255);
    for (int i = 0; i < 45; i++) tick();
    chk("cnt_sat", 32'(err_cnt_o), 255);
    chk("cnt_sat_f", 32'(fatal_cnt_o), 0);
    dec("sat_dbl", 1, 4'b1000, 4'b0001, 4'b1000, 1, 1, 255, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
